// File: rtl/dram_burst_responder_pkg.sv
// Shared definitions for the DRAM burst responder: default geometry,
// address/burst typedefs sized for that geometry, and the burstcount
// sanitising helpers used when a command is first accepted.
package dram_burst_responder_pkg;

  localparam int unsigned DEFAULT_DEPTH     = 1024;
  localparam int unsigned DEFAULT_MAX_BURST = 16;

  typedef logic [$clog2(DEFAULT_DEPTH)-1:0] addr_t;
  typedef logic [$clog2(DEFAULT_MAX_BURST):0] burst_t;

  // Number of beats actually transferred for a requested burstcount:
  // zero is promoted to one, oversize requests are clamped.
  function automatic int unsigned effective_len(input int unsigned bc,
                                                input int unsigned max_burst);
    if (bc == 0) return 1;
    if (bc > max_burst) return max_burst;
    return bc;
  endfunction

  function automatic logic burst_illegal(input int unsigned bc,
                                         input int unsigned max_burst);
    return (bc == 0) || (bc > max_burst);
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Ports: clk, rst_n (clears only the read register), we/waddr/wdata write
// port, re/raddr read enable/address, q registered read data.
// A same-cycle read of the address being written returns the new data.
module sdp_ram #(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         q
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; clearing it
  // would need a per-word reset network the RAM primitives do not have.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (re) begin
      q <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/dram_burst_responder.sv
// Burst-capable memory responder terminating an Avalon-MM-style DRAM
// request stream. Write bursts are stored beat by beat; read bursts are
// returned READ_LATENCY cycles after accept as a gapless beat train.
// Ports: clk, resetn (async, active low), address/burstcount (sampled on
// the first beat), write/writedata, read, waitrequest, readdata,
// readdatavalid (registered), error (sticky protocol violation).
module dram_burst_responder
  import dram_burst_responder_pkg::*;
#(
  parameter int unsigned WIDTH        = 512,
  parameter int unsigned DEPTH        = DEFAULT_DEPTH,
  parameter int unsigned MAX_BURST    = DEFAULT_MAX_BURST,
  parameter int unsigned READ_LATENCY = 4
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [$clog2(DEPTH)-1:0]     address,
  input  logic [$clog2(MAX_BURST):0]   burstcount,
  input  logic                         write,
  input  logic [WIDTH-1:0]             writedata,
  input  logic                         read,
  output logic                         waitrequest,
  output logic [WIDTH-1:0]             readdata,
  output logic                         readdatavalid,
  output logic                         error
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned BW = $clog2(MAX_BURST) + 1;
  localparam int unsigned CW = $clog2(READ_LATENCY) + 1;

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, RD_BURST} state_t;

  state_t          state_q, state_d;
  logic            ready_q;   // low until the first edge after reset
  logic [AW-1:0]   ptr_q;     // next write address / next read issue address
  logic [BW-1:0]   rem_q;     // write: beats still expected; read: beats still to issue
  logic [CW-1:0]   cnt_q;     // latency counter in RD_WAIT
  logic            error_q;
  logic            rdv_q;

  logic            wr_acc, rd_acc, rd_fire, viol;
  logic [BW-1:0]   first_len;
  logic [AW-1:0]   wr_addr;

  // NOTE: every signal driven here gets a value before the case statement,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    waitrequest = !ready_q || (state_q == RD_WAIT) || (state_q == RD_BURST);
    wr_acc      = write && !waitrequest;
    rd_acc      = read && !write && !waitrequest && (state_q == IDLE);
    first_len   = BW'(effective_len(32'(burstcount), MAX_BURST));
    wr_addr     = (state_q == IDLE) ? address : ptr_q;
    // The first RAM read is issued on the last RD_WAIT edge so the beat
    // lands in the RAM output register exactly READ_LATENCY after accept.
    rd_fire     = ((state_q == RD_WAIT) && (cnt_q == CW'(READ_LATENCY - 1))) ||
                  ((state_q == RD_BURST) && (rem_q != '0));
    viol        = !waitrequest &&
                  (((state_q == IDLE) && (read || write) &&
                    burst_illegal(32'(burstcount), MAX_BURST)) ||
                   ((state_q == IDLE) && read && write) ||
                   ((state_q == WR_BURST) && read));
    state_d     = state_q;
    case (state_q)
      IDLE: begin
        if (wr_acc) begin
          if (first_len > BW'(1)) state_d = WR_BURST;
        end else if (rd_acc) begin
          state_d = RD_WAIT;
        end
      end
      WR_BURST: if (wr_acc && (rem_q == BW'(1))) state_d = IDLE;
      RD_WAIT:  if (cnt_q == CW'(READ_LATENCY - 1)) state_d = RD_BURST;
      // Leave once the final beat is on the outputs, not when it is issued,
      // so waitrequest covers the whole beat train.
      RD_BURST: if (rem_q == '0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q <= 1'b0;
      ptr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
      rdv_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      error_q <= error_q | viol;
      rdv_q   <= rd_fire;
      if (wr_acc) begin
        ptr_q <= wr_addr + AW'(1);
        rem_q <= ((state_q == IDLE) ? first_len : rem_q) - BW'(1);
      end else if (rd_acc) begin
        ptr_q <= address;
        rem_q <= first_len;
        cnt_q <= '0;
      end else begin
        if (state_q == RD_WAIT) cnt_q <= cnt_q + CW'(1);
        if (rd_fire) begin
          ptr_q <= ptr_q + AW'(1);
          rem_q <= rem_q - BW'(1);
        end
      end
    end
  end

  sdp_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rst_n (resetn),
    .we    (wr_acc),
    .waddr (wr_addr),
    .wdata (writedata),
    .re    (rd_fire),
    .raddr (ptr_q),
    .q     (readdata)
  );

  assign readdatavalid = rdv_q;
  assign error         = error_q;

endmodule

// File: tb/tb_dram_burst_responder.sv
// Scoreboard bench for dram_burst_responder: read commands push expected
// beats (data from a shadow memory, arrival cycle from the accept edge);
// a negedge monitor pops and compares every readdatavalid beat.
module tb_dram_burst_responder;
  import dram_burst_responder_pkg::*;

  localparam int WIDTH     = 512;
  localparam int DEPTH     = 1024;
  localparam int MAX_BURST = 16;
  localparam int RL        = 4;

  logic             clk = 1'b0;
  logic             resetn = 1'b1;
  addr_t            address = '0;
  burst_t           burstcount = '0;
  logic             write = 1'b0;
  logic [WIDTH-1:0] writedata = '0;
  logic             read = 1'b0;
  logic             waitrequest;
  logic [WIDTH-1:0] readdata;
  logic             readdatavalid;
  logic             error;

  dram_burst_responder #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .resetn(resetn), .address(address), .burstcount(burstcount),
    .write(write), .writedata(writedata), .read(read),
    .waitrequest(waitrequest), .readdata(readdata),
    .readdatavalid(readdatavalid), .error(error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               due;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             mon_e;
  logic [WIDTH-1:0] model [DEPTH];
  int               checks = 0;
  int               errors = 0;
  int               beats_seen = 0;

  function automatic int model_len(input int bc);
    if (bc == 0) return 1;
    if (bc > MAX_BURST) return MAX_BURST;
    return bc;
  endfunction

  always @(negedge clk) begin
    if (readdatavalid === 1'b1) begin
      beats_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: readdatavalid=1 at cycle %0d, required no beat", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (readdata !== mon_e.data || cyc != mon_e.due) begin
          errors++;
          $display("FAIL read_beat: got data %h at cycle %0d, required %h at cycle %0d",
                   readdata, cyc, mon_e.data, mon_e.due);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      write = 1'b0;
      read  = 1'b0;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    write = 1'b0; read = 1'b0; resetn = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // rd_mode: 0 none, 1 read high with the first beat, 2 read high with beat 1.
  // Returns with the last beat still driven; the next task deasserts it.
  task automatic write_burst(input int addr, input int bc, input logic [WIDTH-1:0] base,
                             input int gap_after, input int gap_len, input int rd_mode);
    int len = model_len(bc);
    bit stalled = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      address    = (k == 0) ? addr_t'(addr) : addr_t'($urandom);
      burstcount = (k == 0) ? burst_t'(bc) : burst_t'($urandom);
      write      = 1'b1;
      writedata  = base + WIDTH'(k);
      read       = (rd_mode == 1 && k == 0) || (rd_mode == 2 && k == 1);
      if (waitrequest !== 1'b0) stalled = 1;
      model[(addr + k) % DEPTH] = base + WIDTH'(k);
      if (k == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          write = 1'b0; read = 1'b0;
          writedata = {16{$urandom}};
          if (waitrequest !== 1'b0) stalled = 1;
        end
      end
    end
    checks++;
    if (stalled) begin
      errors++;
      $display("FAIL write_waitrequest: waitrequest=1 during write burst at %0d, required 0", addr);
    end
  endtask

  task automatic read_burst(input int addr, input int bc);
    int len = model_len(bc);
    int t;
    bit ok = 0;
    @(negedge clk);
    write = 1'b0; read = 1'b1;
    address = addr_t'(addr); burstcount = burst_t'(bc);
    for (int i = 0; i < 100; i++) begin
      if (waitrequest === 1'b0) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL read_accept: waitrequest=%b after 100 cycles, required 0", waitrequest);
    end else begin
      t = cyc + 1;
      for (int i = 0; i < len; i++)
        exp_q.push_back('{data: model[(addr + i) % DEPTH], due: t + RL + i});
    end
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats outstanding after 200 cycles, required 0", exp_q.size());
      exp_q.delete();
    end
    idle(2);
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks += 4;
    if (waitrequest !== 1'b1) begin errors++; $display("FAIL rst_waitrequest: got %b, required 1", waitrequest); end
    if (readdatavalid !== 1'b0) begin errors++; $display("FAIL rst_readdatavalid: got %b, required 0", readdatavalid); end
    if (readdata !== '0) begin errors++; $display("FAIL rst_readdata: got %h, required 0", readdata); end
    if (error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b, required 0", error); end
    resetn = 1'b1;
    #1;
    checks++;
    if (waitrequest !== 1'b1) begin errors++; $display("FAIL rst_release_wr: got %b, required 1 before first edge", waitrequest); end
    @(negedge clk);
    checks++;
    if (waitrequest !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b, required 0 after first edge", waitrequest); end
  endtask

  task automatic test_single();
    write_burst(3, 1, {16{32'hA5A5A5A5}}, -1, 0, 0);
    read_burst(3, 1);
    wait_drain();
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL single_error: got %b, required 0", error); end
  endtask

  task automatic test_wrap_burst();
    write_burst(DEPTH - 2, 16, '0, -1, 0, 0);
    read_burst(DEPTH - 2, 16);
    wait_drain();
    read_burst(0, 14);
    wait_drain();
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL wrap_error: got %b, required 0", error); end
  endtask

  task automatic test_gapped();
    write_burst(100, 4, {16{32'h1234_5678}}, 1, 2, 0);
    read_burst(100, 4);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int t, hi = 0;
    bit freed = 0;
    write_burst(200, 8, {16{32'hC0DE_0000}}, -1, 0, 0);
    @(negedge clk);
    write = 1'b0; read = 1'b1; address = addr_t'(200); burstcount = burst_t'(8);
    checks++;
    if (waitrequest !== 1'b0) begin errors++; $display("FAIL bp_first_accept: waitrequest=%b, required 0", waitrequest); end
    t = cyc + 1;
    for (int i = 0; i < 8; i++) exp_q.push_back('{data: model[200 + i], due: t + RL + i});
    @(negedge clk);
    checks++;
    if (waitrequest !== 1'b1) begin errors++; $display("FAIL bp_after_accept: waitrequest=%b, required 1", waitrequest); end
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (waitrequest === 1'b1) hi++;
      else begin freed = 1; break; end
    end
    checks += 2;
    if (hi != RL + 7) begin errors++; $display("FAIL bp_busy_cycles: got %0d, required %0d", hi, RL + 7); end
    if (!freed || cyc != t + RL + 8) begin
      errors++;
      $display("FAIL bp_release: waitrequest low at cycle %0d, required %0d", cyc, t + RL + 8);
    end
    if (freed) begin
      for (int i = 0; i < 8; i++) exp_q.push_back('{data: model[200 + i], due: cyc + 1 + RL + i});
    end
    @(negedge clk);
    read = 1'b0;
    wait_drain();
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL bp_error: got %b, required 0", error); end
  endtask

  task automatic test_protocol_errors();
    apply_reset();
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b, required 0", error); end
    write_burst(300, 1, {16{32'hDEAD_BEEF}}, -1, 0, 1);
    idle(10);
    checks++;
    if (error !== 1'b1) begin errors++; $display("FAIL err_rd_wr: got %b, required 1", error); end
    read_burst(300, 1);
    wait_drain();

    apply_reset();
    read_burst(300, 0);
    wait_drain();
    checks++;
    if (error !== 1'b1) begin errors++; $display("FAIL err_burst0: got %b, required 1", error); end

    apply_reset();
    write_burst(400, 20, {16{32'h0F0F_0000}}, -1, 0, 0);
    idle(1);
    checks++;
    if (error !== 1'b1) begin errors++; $display("FAIL err_clamp: got %b, required 1", error); end
    read_burst(400, 16);
    wait_drain();

    apply_reset();
    write_burst(500, 4, {16{32'h5555_0000}}, -1, 0, 2);
    idle(6);
    checks++;
    if (error !== 1'b1) begin errors++; $display("FAIL err_rd_in_wr: got %b, required 1", error); end
    read_burst(500, 4);
    wait_drain();
  endtask

  task automatic test_reset_mid_read();
    int start;
    bit hit = 0;
    apply_reset();
    start = beats_seen;
    read_burst(DEPTH - 2, 16);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (beats_seen >= start + 3) begin hit = 1; break; end
    end
    resetn = 1'b0;
    #1;
    exp_q.delete();
    checks += 3;
    if (!hit) begin errors++; $display("FAIL mid_beat2: saw %0d beats, required 3", beats_seen - start); end
    if (readdatavalid !== 1'b0) begin errors++; $display("FAIL mid_rdv_drop: got %b, required 0", readdatavalid); end
    if (waitrequest !== 1'b1) begin errors++; $display("FAIL mid_waitrequest: got %b, required 1", waitrequest); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    idle(30);
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL mid_error: got %b, required 0", error); end
    read_burst(DEPTH - 2, 16);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap_burst();
    test_gapped();
    test_back_to_back();
    test_protocol_errors();
    test_reset_mid_read();
    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
